// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with per-register pending bits.
// Decode stalls on rd_ready; optional same-cycle write forwarding.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rd_ready1,
    output logic            rd_ready2,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic [AW:0]     pend_cnt
);

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_v, iss_v, hit1, hit2, inc, dec;

    // Strobes are dead while in reset; this also kills the bypass path.
    assign wr_v  = wr_en & reset_n & (wr_addr != '0);
    assign iss_v = iss_en & reset_n & (iss_addr != '0);
    assign hit1  = BYPASS & wr_v & (wr_addr == rd_addr1);
    assign hit2  = BYPASS & wr_v & (wr_addr == rd_addr2);

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rd_addr1 != '0) rd_data1 = hit1 ? wr_data : regs_q[rd_addr1];
        if (rd_addr2 != '0) rd_data2 = hit2 ? wr_data : regs_q[rd_addr2];
        rd_ready1 = (rd_addr1 == '0) | ~pend_q[rd_addr1] | hit1;
        rd_ready2 = (rd_addr2 == '0) | ~pend_q[rd_addr2] | hit2;
    end

    always_comb begin
        pend_d = pend_q;
        if (wr_v)  pend_d[wr_addr]  = 1'b0;
        if (iss_v) pend_d[iss_addr] = 1'b1;
        inc = iss_v & ~pend_q[iss_addr];
        // A clear that collides with an issue to the same register is void.
        dec = wr_v & pend_q[wr_addr] & ~(iss_v & (iss_addr == wr_addr));
        cnt_d = cnt_q;
        if (inc & ~dec)      cnt_d = cnt_q + ONE;
        else if (dec & ~inc) cnt_d = cnt_q - ONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_v) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed table, corner sequences,
// reset, saturation and random traffic against an array-based model.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  ra1, ra2, wa, ia;
    logic [31:0] d1, d2, wd;
    logic        r1, r2, we, ie;
    logic [5:0]  cnt;

    logic [3:0]  b_ra1, b_ra2, b_wa, b_ia;
    logic [63:0] b_d1, b_d2, b_wd;
    logic        b_r1, b_r2, b_we, b_ie;
    logic [4:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard dut (
        .clock(clk), .reset_n(rst_n),
        .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(d1), .rd_data2(d2),
        .rd_ready1(r1), .rd_ready2(r2),
        .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .iss_en(ie), .iss_addr(ia),
        .pend_cnt(cnt)
    );

    regfile_scoreboard #(.XLEN(64), .NREGS(16), .BYPASS(1'b0)) dut2 (
        .clock(clk), .reset_n(rst_n),
        .rd_addr1(b_ra1), .rd_addr2(b_ra2),
        .rd_data1(b_d1), .rd_data2(b_d2),
        .rd_ready1(b_r1), .rd_ready2(b_r2),
        .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
        .iss_en(b_ie), .iss_addr(b_ia),
        .pend_cnt(b_cnt)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] d1;
        logic        r1;
        logic [31:0] d2;
        logic        r2;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl [16];

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int popcnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic exp_ready(input logic [4:0] a);
        return (a == 0) || !m_pend[a] || (we && wa == a);
    endfunction

    task automatic idle();
        we = 0; wa = 0; wd = 0; ie = 0; ia = 0;
        b_we = 0; b_wa = 0; b_wd = 0; b_ie = 0; b_ia = 0;
    endtask

    initial begin
        // we wa wd ie ia ra1 ra2 d1 r1 d2 r2 cnt
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 1, 0, 1, 0};
        tbl[1]  = '{1, 0, 32'h1234, 0, 0, 5, 0, 32'hDEADBEEF, 1, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 7, 0, 7, 0, 1, 0, 1, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 1, 0, 0, 1};
        tbl[4]  = '{1, 7, 32'h55, 0, 0, 7, 7, 32'h55, 1, 32'h55, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 7, 0, 1, 32'h55, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 9, 9, 0, 0, 1, 0, 1, 1};
        tbl[7]  = '{1, 9, 32'hA5A5A5A5, 0, 0, 9, 9, 32'hA5A5A5A5, 1,
                    32'hA5A5A5A5, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 3, 3, 0, 0, 1, 0, 1, 1};
        tbl[9]  = '{1, 3, 32'h11, 1, 3, 3, 0, 32'h11, 1, 0, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 3, 0, 32'h11, 0, 0, 1, 1};
        tbl[11] = '{1, 3, 32'h22, 1, 4, 3, 4, 32'h22, 1, 0, 1, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 3, 4, 32'h22, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 4, 3, 4, 32'h22, 1, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 1, 0, 0, 4, 0, 1, 0, 0, 1};
        tbl[15] = '{1, 4, 32'h77, 0, 0, 0, 4, 0, 1, 32'h77, 1, 0};

        rst_n = 0;
        idle();
        ra1 = 5; ra2 = 9; b_ra1 = 3; b_ra2 = 0;
        #12;
        chk("rst_d1", d1, 0);
        chk("rst_r1", r1, 1);
        chk("rst_cnt", cnt, 0);
        chk("rst_b_cnt", b_cnt, 0);
        #5 rst_n = 1;
        tick();

        foreach (tbl[i]) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            ie = tbl[i].ie; ia = tbl[i].ia;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            #1;
            chk($sformatf("tbl%0d_d1", i), d1, tbl[i].d1);
            chk($sformatf("tbl%0d_r1", i), r1, tbl[i].r1);
            chk($sformatf("tbl%0d_d2", i), d2, tbl[i].d2);
            chk($sformatf("tbl%0d_r2", i), r2, tbl[i].r2);
            tick();
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
        end
        idle();

        // Saturation on the 32-entry instance.
        for (int i = 1; i < 32; i++) begin
            ie = 1; ia = 5'(i);
            tick();
        end
        ie = 0; ra1 = 31;
        #1;
        chk("sat_cnt", cnt, 31);
        chk("sat_r31", r1, 0);
        ie = 1; ia = 0;
        tick();
        chk("sat_x0", cnt, 31);
        ie = 0;
        for (int i = 1; i < 32; i++) begin
            we = 1; wa = 5'(i); wd = 32'(i * 3);
            tick();
        end
        we = 0;
        #1;
        chk("sat_drain", cnt, 0);
        chk("sat_d31", d1, 93);
        chk("sat_r31b", r1, 1);

        // No-bypass 64-bit / 16-entry instance.
        b_ie = 1; b_ia = 9;
        tick();
        b_ie = 0;
        chk("b_cnt1", b_cnt, 1);
        b_we = 1; b_wa = 9; b_wd = 64'hA5A5A5A5A5A5A5A5; b_ra1 = 9;
        #1;
        chk("b_nobyp_d1", b_d1, 0);
        chk("b_nobyp_r1", b_r1, 0);
        tick();
        b_we = 0;
        chk("b_after_d1", b_d1, 64'hA5A5A5A5A5A5A5A5);
        chk("b_after_r1", b_r1, 1);
        chk("b_cnt0", b_cnt, 0);
        b_we = 1; b_wa = 0; b_wd = 64'h1234; b_ra2 = 0;
        tick();
        b_we = 0;
        chk("b_x0", b_d2, 0);
        for (int i = 1; i < 16; i++) begin
            b_ie = 1; b_ia = 4'(i);
            tick();
        end
        b_ie = 1; b_ia = 0;
        chk("b_sat", b_cnt, 15);
        tick();
        b_ie = 0;
        chk("b_sat_x0", b_cnt, 15);
        for (int i = 1; i < 16; i++) begin
            b_we = 1; b_wa = 4'(i); b_wd = {32'(i), 32'hF00D0000};
            tick();
        end
        b_we = 0; b_ra2 = 15;
        #1;
        chk("b_drain", b_cnt, 0);
        chk("b_d15", b_d2, {32'd15, 32'hF00D0000});

        // Reset asserted mid-cycle with live data and a pending register.
        we = 1; wa = 5; wd = 32'hCAFEF00D; ie = 1; ia = 7;
        tick();
        we = 0; ie = 0; ra1 = 5;
        #1;
        chk("pre_rst_d1", d1, 32'hCAFEF00D);
        chk("pre_rst_cnt", cnt, 1);
        #1;
        rst_n = 0;
        we = 1; wa = 6; wd = 32'h600D; ie = 1; ia = 8;
        #1;
        chk("mid_rst_d1", d1, 0);
        chk("mid_rst_r1", r1, 1);
        chk("mid_rst_cnt", cnt, 0);
        ra1 = 6;
        #1;
        chk("mid_rst_byp", d1, 0);
        tick();
        rst_n = 1;
        idle();
        ra2 = 8;
        #1;
        chk("post_rst_d6", d1, 0);
        chk("post_rst_r8", r2, 1);
        chk("post_rst_cnt", cnt, 0);
        tick();

        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_pend[i] = 0;
        end

        // Random traffic, addresses biased low to force collisions.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 2) == 0);
            wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5))
                                              : 5'($urandom);
            ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5))
                                              : 5'($urandom);
            ra1 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 1) != 0) ? ia : 5'($urandom);
            wd = $urandom;
            #1;
            chk("rnd_d1", d1, exp_data(ra1));
            chk("rnd_r1", r1, exp_ready(ra1));
            chk("rnd_d2", d2, exp_data(ra2));
            chk("rnd_r2", r2, exp_ready(ra2));
            @(posedge clk);
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_pend[wa] = 0;
            end
            if (ie && ia != 0) m_pend[ia] = 1;
            #1;
            chk("rnd_cnt", cnt, 64'(popcnt()));
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
